// File: rtl/mult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mult_rr_arbiter
//   Round-robin arbiter that shares one fixed-latency pipelined multiplier
//   among NREQ requesters. At most one operand pair is issued per cycle. A tag
//   pipeline running alongside the multiplier records which requester owns
//   each product, so the product can be returned with a one-hot valid.
//
// Parameters
//   WIDTH    operand width; the product is 2*WIDTH bits
//   NREQ     number of requesters (>= 2)
//   LATENCY  multiplier cycles from sampling mul_a/mul_b to mul_result valid
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   clr_i          synchronous active-high clear
//   req_valid_i    [NREQ]        requester i has operands pending
//   req_a_i        [NREQ*WIDTH]  operand a; requester i in [i*WIDTH +: WIDTH]
//   req_b_i        [NREQ*WIDTH]  operand b; same packing
//   req_ready_o    [NREQ]        one-hot or zero grant (handshake = valid&ready)
//   mul_a_o        [WIDTH]       registered operand a to the multiplier
//   mul_b_o        [WIDTH]       registered operand b to the multiplier
//   mul_result_i   [2*WIDTH]     product from the multiplier
//   rsp_valid_o    [NREQ]        one-hot single-cycle pulse: product for i
//   rsp_result_o   [2*WIDTH]     product; meaningful only while |rsp_valid_o
// -----------------------------------------------------------------------------
module mult_rr_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int LATENCY = 3
) (
  input  logic                    clk_i,
  input  logic                    clr_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [WIDTH-1:0]        mul_a_o,
  output logic [WIDTH-1:0]        mul_b_o,
  input  logic [2*WIDTH-1:0]      mul_result_i,
  output logic [NREQ-1:0]         rsp_valid_o,
  output logic [2*WIDTH-1:0]      rsp_result_o
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // State
  logic [IDX_W-1:0]              ptr_q,     ptr_d;
  logic [NREQ-1:0]               pending_q, pending_d;
  logic [WIDTH-1:0]              mul_a_q,   mul_b_q;
  logic [NREQ-1:0]               rsp_valid_q;
  logic [2*WIDTH-1:0]            rsp_result_q;
  // Tag stage 0 is loaded at the issue edge; stages 1..LATENCY track the
  // multiplier, so the last stage lines up with mul_result_i.
  logic [LATENCY:0]              tag_vld_q;
  logic [LATENCY:0][IDX_W-1:0]   tag_id_q;

  // Combinational
  logic [NREQ-1:0]   elig;
  logic              grant_vld;
  logic [IDX_W-1:0]  grant_idx;
  logic [NREQ-1:0]   grant_oh;
  logic [NREQ-1:0]   rsp_set;
  logic [WIDTH-1:0]  sel_a, sel_b;
  int                scan_idx;

  // A requester with an op outstanding may re-issue in its own response cycle.
  assign elig = req_valid_i & (~pending_q | rsp_valid_q);

  // Round-robin search: scan offsets from farthest to nearest so the first
  // eligible index at or after ptr_q is the one left standing.
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      scan_idx = int'(ptr_q) + off;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (elig[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(scan_idx);
      end
    end
    // No grant may be offered while the block is being cleared.
    if (clr_i) grant_vld = 1'b0;
  end

  always_comb begin
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a = req_a_i[i*WIDTH +: WIDTH];
        sel_b = req_b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointer moves just past the winner; idle cycles leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      if (grant_idx == IDX_W'(NREQ - 1)) ptr_d = '0;
      else                               ptr_d = grant_idx + 1'b1;
    end
  end

  // Owner of the product arriving on mul_result_i this cycle.
  always_comb begin
    rsp_set = '0;
    if (tag_vld_q[LATENCY]) rsp_set[tag_id_q[LATENCY]] = 1'b1;
  end

  // A fresh grant wins over a completing response for the same requester.
  assign pending_d = (pending_q & ~rsp_set) | grant_oh;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      // NOTE: the tag pipe is a handful of flops, not a RAM; clearing it is
      // what drops in-flight ops so they never raise rsp_valid.
      ptr_q        <= '0;
      pending_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      // Idle cycles feed zeros so the multiplier inputs are deterministic.
      mul_a_q   <= grant_vld ? sel_a : '0;
      mul_b_q   <= grant_vld ? sel_b : '0;

      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_idx;
      for (int s = 1; s <= LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end

      rsp_valid_q <= rsp_set;
      if (tag_vld_q[LATENCY]) rsp_result_q <= mul_result_i;
    end
  end

  assign req_ready_o  = grant_oh;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_rr_arbiter
//   Drives directed scenarios and a random phase into mult_rr_arbiter with a
//   pipelined multiplier stand-in. The reference model is transaction level:
//   a queue of issued ops (owner, product, cycle its response becomes
//   visible) plus a round-robin pointer. Requester i is busy while it owns an
//   op whose response cycle lies in the future.
// -----------------------------------------------------------------------------
module tb_mult_rr_arbiter;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int LATENCY = 3;

  logic                    clk = 1'b0;
  logic                    clr;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_a, req_b;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        mul_a, mul_b;
  logic [2*WIDTH-1:0]      mul_result;
  logic [NREQ-1:0]         rsp_valid;
  logic [2*WIDTH-1:0]      rsp_result;

  always #5 clk = ~clk;

  mult_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk_i        (clk),
    .clr_i        (clr),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_result_i (mul_result),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result)
  );

  // Multiplier stand-in: samples mul_a/mul_b at an edge, product visible
  // LATENCY edges later.
  logic [2*WIDTH-1:0] mpipe [LATENCY];
  initial for (int j = 0; j < LATENCY; j++) mpipe[j] = '0;
  always @(posedge clk) begin
    mpipe[0] <= {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    for (int j = 1; j < LATENCY; j++) mpipe[j] <= mpipe[j-1];
  end
  assign mul_result = mpipe[LATENCY-1];

  // ---------------------------------------------------------------- model
  typedef struct {
    int owner;
    int prod;
    int due;
  } op_t;

  op_t              q[$];
  int               ptr_m;
  int               cyc;
  logic [WIDTH-1:0] exp_ma, exp_mb;
  int               rsp_seen [NREQ];
  int               rsp_exp  [NREQ];
  int               last_rsp_cyc [NREQ];
  logic [NREQ-1:0]  last_ready;

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int b);
    req_valid[i]             = v;
    req_a[i*WIDTH +: WIDTH]  = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH]  = WIDTH'(b);
  endtask

  // One clock cycle: inputs were driven at the preceding negedge.
  task automatic cycle();
    int              g;
    bit              busy;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rsp;
    int              exp_res;
    op_t             keep[$];

    #1;
    g = -1;
    if (!clr) begin
      for (int off = 0; off < NREQ; off++) begin
        idx  = (ptr_m + off) % NREQ;
        busy = 1'b0;
        foreach (q[k]) if (q[k].owner == idx && q[k].due > cyc) busy = 1'b1;
        if (g < 0 && req_valid[idx] && !busy) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rsp = '0;
    exp_res = 0;
    foreach (q[k]) if (q[k].due == cyc) begin
      exp_rsp[q[k].owner] = 1'b1;
      exp_res             = q[k].prod;
    end

    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("mul_a", 32'(mul_a), 32'(exp_ma));
    check("mul_b", 32'(mul_b), 32'(exp_mb));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != '0) check("rsp_result", 32'(rsp_result), 32'(exp_res));

    for (int i = 0; i < NREQ; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        rsp_seen[i]++;
        last_rsp_cyc[i] = cyc;
      end
      if (exp_rsp[i]) rsp_exp[i]++;
    end
    last_ready = req_ready;

    @(posedge clk);
    if (clr) begin
      q.delete();
      ptr_m  = 0;
      exp_ma = '0;
      exp_mb = '0;
    end else begin
      foreach (q[k]) if (q[k].due > cyc) keep.push_back(q[k]);
      q = keep;
      if (g >= 0) begin
        exp_ma = req_a[g*WIDTH +: WIDTH];
        exp_mb = req_b[g*WIDTH +: WIDTH];
        q.push_back('{owner: g, prod: int'(exp_ma) * int'(exp_mb), due: cyc + LATENCY + 2});
        ptr_m = (g + 1) % NREQ;
      end else begin
        exp_ma = '0;
        exp_mb = '0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------------------------------------------------------- stimulus
  int  base_seen [NREQ];
  int  g_cyc, r_cyc;
  bit  found;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; ptr_m = 0;
    exp_ma = '0; exp_mb = '0; last_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_seen[i] = 0; rsp_exp[i] = 0; last_rsp_cyc[i] = -1;
    end
    clr = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // 1: clear held with every requester valid
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 1, i + 2);
    cycle();
    cycle();
    check("t1_ready_in_clr", 32'(last_ready), 32'h0);
    clr = 1'b0;
    req_valid = '0;
    cycle();

    // 2: single op from requester 0
    set_req(0, 1'b1, 12, 13);
    g_cyc = cyc;
    cycle();
    check("t2_grant", 32'(last_ready), 32'b0001);
    base_seen[0] = rsp_seen[0];
    idle(LATENCY + 5);
    check("t2_pulses", 32'(rsp_seen[0] - base_seen[0]), 32'd1);
    check("t2_latency", 32'(last_rsp_cyc[0] - g_cyc), 32'(LATENCY + 2));

    // 3: everyone valid; ptr is 1 after test 2, so restart order from reset
    clr = 1'b1; cycle(); clr = 1'b0;
    set_req(0, 1'b1, 255, 255);
    set_req(1, 1'b1, 0, 7);
    set_req(2, 1'b1, 1, 1);
    set_req(3, 1'b1, 128, 2);
    for (int i = 0; i < NREQ; i++) begin
      cycle();
      check("t3_grant_order", 32'(last_ready), 32'(1 << i));
    end
    cycle();
    check("t3_no_grant_while_busy", 32'(last_ready), 32'h0);
    for (int i = 0; i < 10; i++) cycle();
    idle(LATENCY + 4);

    // 4: pointer wrap after a grant to requester 3
    set_req(3, 1'b1, 9, 10);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle();
      if (last_ready[3] === 1'b1) found = 1'b1;
    end
    check("t4_grant3", 32'(found), 32'd1);
    req_valid = '0;
    set_req(1, 1'b1, 17, 3);
    set_req(2, 1'b1, 200, 4);
    cycle();
    check("t4_wrap_first", 32'(last_ready), 32'b0010);
    cycle();
    check("t4_wrap_second", 32'(last_ready), 32'b0100);
    idle(LATENCY + 4);

    // 5: requester 2 re-issues in its own response cycle
    base_seen[2] = rsp_seen[2];
    set_req(2, 1'b1, 9, 9);
    g_cyc = cyc;
    cycle();
    check("t5_first_grant", 32'(last_ready), 32'b0100);
    set_req(2, 1'b1, 3, 5);
    found = 1'b0;
    r_cyc = -1;
    for (int i = 0; i < 12 && !found; i++) begin
      r_cyc = cyc;
      cycle();
      if (last_ready[2] === 1'b1) found = 1'b1;
    end
    check("t5_regrant_seen", 32'(found), 32'd1);
    check("t5_regrant_cycle", 32'(r_cyc - g_cyc), 32'(LATENCY + 2));
    req_valid = '0;
    idle(LATENCY + 5);
    check("t5_pulses", 32'(rsp_seen[2] - base_seen[2]), 32'd2);

    // 6: clear while three ops are in flight
    for (int i = 0; i < NREQ; i++) base_seen[i] = rsp_seen[i];
    set_req(0, 1'b1, 21, 2);
    set_req(1, 1'b1, 22, 3);
    set_req(2, 1'b1, 23, 4);
    for (int i = 0; i < 3; i++) cycle();
    req_valid = '0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    set_req(0, 1'b1, 6, 7);
    cycle();
    check("t6_post_clr_grant", 32'(last_ready), 32'b0001);
    idle(LATENCY + 5);
    check("t6_req0_pulses", 32'(rsp_seen[0] - base_seen[0]), 32'd1);
    check("t6_req1_dropped", 32'(rsp_seen[1] - base_seen[1]), 32'd0);
    check("t6_req2_dropped", 32'(rsp_seen[2] - base_seen[2]), 32'd0);

    // Random traffic with occasional clears
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)));
      clr = ($urandom_range(0, 49) == 0);
      cycle();
    end
    clr = 1'b0;
    idle(LATENCY + 5);

    for (int i = 0; i < NREQ; i++) check("total_pulses", 32'(rsp_seen[i]), 32'(rsp_exp[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
